// File: rtl/freq_div_strobe_if.sv
// -----------------------------------------------------------------------------
// freq_div_strobe_if
//   Control and status bundle for the programmable frequency divider.
//   master: the controller that drives run/div_load/div_val and observes
//           the strobe, divided clock and status.
//   slave : the divider itself.
//
//   run       master->slave  level: 1 = divider runs, 0 = finish period and idle
//   div_load  master->slave  one-cycle pulse: capture div_val as new divisor
//   div_val   master->slave  requested divisor (legal 2..2^CNT_W-1)
//   C2        slave->master  one-cycle enable strobe, once per period
//   clk_div   slave->master  divided square wave
//   busy      slave->master  divider is counting (RUN or STOP)
//   tick_cnt  slave->master  number of C2 strobes issued, 8-bit wrap
//   div_err   slave->master  sticky: last div_load carried 0 or 1
// -----------------------------------------------------------------------------
interface freq_div_strobe_if #(
  parameter int CNT_W = 4
);
  logic             run;
  logic             div_load;
  logic [CNT_W-1:0] div_val;
  logic             C2;
  logic             clk_div;
  logic             busy;
  logic [7:0]       tick_cnt;
  logic             div_err;

  modport master (
    output run, div_load, div_val,
    input  C2, clk_div, busy, tick_cnt, div_err
  );

  modport slave (
    input  run, div_load, div_val,
    output C2, clk_div, busy, tick_cnt, div_err
  );
endinterface

// File: rtl/freq_div_strobe.sv
// -----------------------------------------------------------------------------
// freq_div_strobe
//   Programmable frequency divider producing a one-cycle enable strobe (C2)
//   every DIV clock cycles plus a divided square wave (clk_div). Supports
//   run/stop with clean completion of the current period and glitch-free
//   divisor changes that take effect only on a period boundary.
//
//   clk   in  system clock, rising edge
//   rst   in  asynchronous active-low reset
//   bus   slave modport of freq_div_strobe_if (run, div_load, div_val,
//         C2, clk_div, busy, tick_cnt, div_err)
//
//   All outputs are registered.
// -----------------------------------------------------------------------------
module freq_div_strobe #(
  parameter int CNT_W       = 4,
  parameter int DEFAULT_DIV = 8
) (
  input  logic             clk,
  input  logic             rst,
  freq_div_strobe_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_STOP = 2'b10
  } state_t;

  localparam logic [CNT_W-1:0] DIV_RST = CNT_W'(DEFAULT_DIV);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0] TWO     = CNT_W'(2);
  localparam logic [CNT_W-1:0] ZERO    = CNT_W'(0);

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_div_act;
  logic [CNT_W-1:0] r_pend;
  logic             r_pend_vld;
  logic             r_c2;
  logic             r_clk_div;
  logic             r_busy;
  logic             r_div_err;
  logic [7:0]       r_tick_cnt;

  state_t           w_state_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [CNT_W-1:0] w_div_nxt;
  logic [CNT_W-1:0] w_pend_nxt;
  logic             w_pend_vld_nxt;
  logic             w_err_nxt;
  logic             w_load_ok;
  logic             w_load_bad;
  logic             w_tc;

  // ceil(d/2): number of high cycles of clk_div in a period of length d
  function automatic logic [CNT_W-1:0] half_up(input logic [CNT_W-1:0] d);
    logic [CNT_W:0] sum;
    sum = {1'b0, d} + {{CNT_W{1'b0}}, 1'b1};
    return sum[CNT_W:1];
  endfunction

  // Next-state, counter, divisor and pending-divisor decode
  always_comb begin
    w_load_ok      = bus.div_load && (bus.div_val >= TWO);
    w_load_bad     = bus.div_load && (bus.div_val < TWO);
    w_tc           = (r_state != ST_IDLE) && (r_cnt == (r_div_act - ONE));
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_div_nxt      = r_div_act;
    w_pend_nxt     = r_pend;
    w_pend_vld_nxt = r_pend_vld;
    w_err_nxt      = r_div_err;

    case (r_state)
      ST_IDLE: begin
        w_cnt_nxt = ZERO;
        // A divisor left pending while idle is adopted straight away
        if (r_pend_vld) begin
          w_div_nxt      = r_pend;
          w_pend_vld_nxt = 1'b0;
        end else begin
          w_div_nxt = r_div_act;
        end
        if (bus.run) begin
          w_state_nxt = ST_RUN;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_RUN, ST_STOP: begin
        if (w_tc) begin
          w_cnt_nxt = ZERO;
          // A load arriving on the terminal-count edge beats the older pending value
          if (w_load_ok) begin
            w_div_nxt = bus.div_val;
          end else if (r_pend_vld) begin
            w_div_nxt = r_pend;
          end else begin
            w_div_nxt = r_div_act;
          end
          w_pend_vld_nxt = 1'b0;
          // run low at the period end (in RUN or STOP) means this was the last period
          if (bus.run) begin
            w_state_nxt = ST_RUN;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end else begin
          w_cnt_nxt = r_cnt + ONE;
          if (bus.run) begin
            w_state_nxt = ST_RUN;
          end else begin
            w_state_nxt = ST_STOP;
          end
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = ZERO;
      end
    endcase

    // Divisor requests: legal values queue up (last wins), illegal ones only flag
    if (w_load_ok) begin
      w_pend_nxt = bus.div_val;
      w_err_nxt  = 1'b0;
      if (w_tc) begin
        w_pend_vld_nxt = 1'b0;
      end else begin
        w_pend_vld_nxt = 1'b1;
      end
    end else if (w_load_bad) begin
      w_err_nxt = 1'b1;
    end else begin
      w_err_nxt = r_div_err;
    end
  end

  // FSM state, counter and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= ST_IDLE;
      r_cnt      <= ZERO;
      r_div_act  <= DIV_RST;
      r_pend     <= DIV_RST;
      r_pend_vld <= 1'b0;
      r_c2       <= 1'b0;
      r_clk_div  <= 1'b0;
      r_busy     <= 1'b0;
      r_div_err  <= 1'b0;
      r_tick_cnt <= 8'd0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_div_act  <= w_div_nxt;
      r_pend     <= w_pend_nxt;
      r_pend_vld <= w_pend_vld_nxt;
      r_div_err  <= w_err_nxt;
      r_c2       <= w_tc;
      // Outputs are computed from next-cycle values so they line up with r_cnt
      r_clk_div  <= (w_state_nxt != ST_IDLE) && (w_cnt_nxt < half_up(w_div_nxt));
      r_busy     <= (w_state_nxt != ST_IDLE);
      if (w_tc) begin
        r_tick_cnt <= r_tick_cnt + 8'd1;
      end else begin
        r_tick_cnt <= r_tick_cnt;
      end
    end
  end

  assign bus.C2       = r_c2;
  assign bus.clk_div  = r_clk_div;
  assign bus.busy     = r_busy;
  assign bus.tick_cnt = r_tick_cnt;
  assign bus.div_err  = r_div_err;

endmodule

// File: tb/tb_freq_div_strobe.sv
// -----------------------------------------------------------------------------
// tb_freq_div_strobe
//   Directed bench for freq_div_strobe. Stimulus pushes the expected
//   (cycle, tick_cnt) of every C2 strobe into a queue; an independent monitor
//   pops and compares whenever C2 is seen high. Level outputs are checked
//   directly at chosen cycles. cyc counts rising edges; all sampling and
//   driving happens on the falling edge.
// -----------------------------------------------------------------------------
module tb_freq_div_strobe;

  typedef struct {
    int cyc;
    int tick;
  } exp_t;

  logic clk;
  logic rst;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  exp_t exp_q[$];

  freq_div_strobe_if #(.CNT_W(4)) bus ();

  freq_div_strobe #(.CNT_W(4), .DEFAULT_DIV(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int want);
    total = total + 1;
    if (act != want) begin
      bad = bad + 1;
      $display("FAIL %s: got %0d want %0d (cyc %0d)", name, act, want, cyc);
    end
  endtask

  task automatic push(input int c, input int t);
    exp_t e;
    e.cyc  = c;
    e.tick = t % 256;
    exp_q.push_back(e);
  endtask

  task automatic wait_cyc(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  task automatic load(input int v);
    bus.div_load = 1'b1;
    bus.div_val  = 4'(v);
    @(negedge clk);
    bus.div_load = 1'b0;
  endtask

  task automatic sample(input int n, output logic [7:0] p);
    p = 8'd0;
    for (int i = 0; i < n; i++) begin
      p = {p[6:0], bus.clk_div};
      @(negedge clk);
    end
  endtask

  // Scoreboard monitor: every C2 must match the next expected strobe
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (bus.C2 === 1'b1) begin
        total = total + 1;
        if (exp_q.size() == 0) begin
          bad = bad + 1;
          $display("FAIL c2_extra: got strobe at cyc %0d want none", cyc);
        end else begin
          e = exp_q.pop_front();
          if (e.cyc != cyc || e.tick != int'(bus.tick_cnt)) begin
            bad = bad + 1;
            $display("FAIL c2_strobe: got cyc %0d tick %0d want cyc %0d tick %0d",
                     cyc, bus.tick_cnt, e.cyc, e.tick);
          end
        end
      end
    end
  end

  initial begin
    int c0, c1, c2;
    logic [7:0] p;
    logic allb;
    rst = 1'b0;
    bus.run = 1'b0;
    bus.div_load = 1'b0;
    bus.div_val = 4'd0;
    repeat (3) @(negedge clk);
    chk("rst_c2", int'(bus.C2), 0);
    chk("rst_clkdiv", int'(bus.clk_div), 0);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_tick", int'(bus.tick_cnt), 0);
    chk("rst_err", int'(bus.div_err), 0);
    rst = 1'b1;

    // 1: run with default divisor 8
    @(negedge clk);
    c0 = cyc;
    bus.run = 1'b1;
    push(c0 + 9, 1);  push(c0 + 17, 2); push(c0 + 25, 3);
    // 2: load 5 at cnt=3 -> period at c0+33 still 8, then 5s
    push(c0 + 33, 4); push(c0 + 38, 5); push(c0 + 43, 6);
    // 3: load 8 at c0+43 -> applies at c0+48; stop at cnt=2 -> final C2
    push(c0 + 48, 7); push(c0 + 56, 8); push(c0 + 64, 9);
    wait_cyc(c0 + 1);
    chk("busy_run", int'(bus.busy), 1);
    sample(8, p);
    chk("clkdiv_div8", int'(p), 8'hF0);
    wait_cyc(c0 + 25);
    chk("tick_3", int'(bus.tick_cnt), 3);
    wait_cyc(c0 + 28);
    load(5);
    wait_cyc(c0 + 33);
    sample(5, p);
    chk("clkdiv_div5", int'(p), 8'h1C);
    wait_cyc(c0 + 43);
    load(8);
    wait_cyc(c0 + 58);
    bus.run = 1'b0;
    wait_cyc(c0 + 63);
    chk("busy_stop", int'(bus.busy), 1);
    wait_cyc(c0 + 64);
    chk("busy_idle", int'(bus.busy), 0);
    chk("clkdiv_idle", int'(bus.clk_div), 0);

    // 3b: drop and re-raise run inside one period
    wait_cyc(c0 + 66);
    c1 = cyc;
    bus.run = 1'b1;
    push(c1 + 9, 10);  push(c1 + 17, 11); push(c1 + 25, 12);
    // 4: illegal load keeps 8, load 3 at c1+26 applies at c1+33
    push(c1 + 33, 13); push(c1 + 36, 14); push(c1 + 39, 15);
    // 5: load 2 at c1+39 applies at c1+42; 260 strobes with wrap
    for (int k = 0; k < 260; k++) push(c1 + 42 + 2 * k, 16 + k);
    wait_cyc(c1 + 3);
    bus.run = 1'b0;
    allb = 1'b1;
    repeat (2) begin
      @(negedge clk);
      allb = allb & bus.busy;
    end
    bus.run = 1'b1;
    repeat (4) begin
      @(negedge clk);
      allb = allb & bus.busy;
    end
    chk("busy_rerun", int'(allb), 1);
    wait_cyc(c1 + 18);
    load(1);
    chk("err_set", int'(bus.div_err), 1);
    wait_cyc(c1 + 26);
    load(3);
    chk("err_clr", int'(bus.div_err), 0);
    wait_cyc(c1 + 33);
    sample(3, p);
    chk("clkdiv_div3", int'(p), 8'h06);
    wait_cyc(c1 + 39);
    load(2);
    wait_cyc(c1 + 522);
    chk("tick_wrap", int'(bus.tick_cnt), 0);
    wait_cyc(c1 + 559);
    bus.run = 1'b0;

    // 6: async reset at cnt=5, then restart with the default divisor
    wait_cyc(c1 + 562);
    load(8);
    wait_cyc(c1 + 566);
    c2 = cyc;
    bus.run = 1'b1;
    wait_cyc(c2 + 6);
    chk("pre_rst_busy", int'(bus.busy), 1);
    rst = 1'b0;
    #1;
    chk("arst_c2", int'(bus.C2), 0);
    chk("arst_clkdiv", int'(bus.clk_div), 0);
    chk("arst_busy", int'(bus.busy), 0);
    chk("arst_tick", int'(bus.tick_cnt), 0);
    chk("arst_err", int'(bus.div_err), 0);
    wait_cyc(c2 + 8);
    rst = 1'b1;
    push(c2 + 17, 1);
    push(c2 + 25, 2);
    wait_cyc(c2 + 18);
    bus.run = 1'b0;
    wait_cyc(c2 + 30);
    chk("queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
